// File: rtl/exec_pkg.sv
// exec_pkg: shared types, encodings and decode for the execute stage.
// Mul/div decode exists only when EXEC_MULDIV_EN is defined.
package exec_pkg;

   typedef enum logic [4:0] {
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SRA, OP_SLT, OP_SLTU,
      OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
      OP_DIV, OP_DIVU, OP_REM, OP_REMU,
      OP_ILL
   } alu_op_e;

   localparam logic [1:0] ALUOP_MEM = 2'b00;
   localparam logic [1:0] ALUOP_BR  = 2'b01;
   localparam logic [1:0] ALUOP_R   = 2'b10;
   localparam logic [1:0] ALUOP_I   = 2'b11;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MD   = 7'b0000001;

   typedef enum logic [1:0] {
      S_IDLE, S_BUSY, S_DONE
   } state_e;

   localparam int CTL_MEMTOREG = 4;
   localparam int CTL_REGWRITE = 3;
   localparam int CTL_MEMREAD  = 2;
   localparam int CTL_MEMWRITE = 1;
   localparam int CTL_BRANCH   = 0;

   // funct3 map shared by R- and I-type; alt picks sub/sra
   function automatic alu_op_e base_op(
      input logic [2:0] f3,
      input logic       alt
   );
      alu_op_e op;
      case (f3)
         3'b000:  op = alt ? OP_SUB : OP_ADD;
         3'b001:  op = OP_SLL;
         3'b010:  op = OP_SLT;
         3'b011:  op = OP_SLTU;
         3'b100:  op = OP_XOR;
         3'b101:  op = alt ? OP_SRA : OP_SRL;
         3'b110:  op = OP_OR;
         default: op = OP_AND;
      endcase
      return op;
   endfunction

   function automatic alu_op_e md_op(input logic [2:0] f3);
      alu_op_e op;
      case (f3)
         3'b000:  op = OP_MUL;
         3'b001:  op = OP_MULH;
         3'b010:  op = OP_MULHSU;
         3'b011:  op = OP_MULHU;
         3'b100:  op = OP_DIV;
         3'b101:  op = OP_DIVU;
         3'b110:  op = OP_REM;
         default: op = OP_REMU;
      endcase
      return op;
   endfunction

   function automatic alu_op_e alu_decode(
      input logic [1:0] aluop,
      input logic [2:0] f3,
      input logic [6:0] f7
   );
      alu_op_e op;
      op = OP_ILL;
      case (aluop)
         ALUOP_MEM: op = OP_ADD;
         ALUOP_BR: begin
            if (f3 != 3'b010 && f3 != 3'b011)
               op = OP_SUB;
         end
         ALUOP_R: begin
            if (f7 == F7_BASE)
               op = base_op(f3, 1'b0);
            else if (f7 == F7_ALT &&
                     (f3 == 3'b000 || f3 == 3'b101))
               op = base_op(f3, 1'b1);
`ifdef EXEC_MULDIV_EN
            else if (f7 == F7_MD)
               op = md_op(f3);
`endif
         end
         ALUOP_I: begin
            if (f3 == 3'b000)
               op = OP_ADD;
            else
               op = base_op(f3, f7[5]);
         end
         default: op = OP_ILL;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/exec_stage_pipe_muldiv_iter.sv
// muldiv_iter: shift-add multiplier and restoring divider, one bit/cycle.
// Compiled only when EXEC_MULDIV_EN is defined.
`ifdef EXEC_MULDIV_EN
module muldiv_iter
   import exec_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            kill,
   input  logic            start,
   input  alu_op_e         op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int CW = $clog2(XLEN);

   logic [CW-1:0]     cnt;
   alu_op_e           op_r;
   logic              is_div_r;
   logic              neg_lo;
   logic              neg_hi;
   logic              div0;
   logic [XLEN-1:0]   a_keep;
   logic [XLEN-1:0]   opnd;
   logic [2*XLEN-1:0] acc;

   logic              is_div;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   ua;
   logic [XLEN-1:0]   ub;
   logic [XLEN:0]     msum;
   logic [XLEN:0]     dsub;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] prod;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;

   assign is_div = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
   assign a_neg  = a[XLEN-1] &&
                   (op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
   assign b_neg  = b[XLEN-1] &&
                   (op inside {OP_MULH, OP_DIV, OP_REM});
   assign ua     = a_neg ? (~a + 1'b1) : a;
   assign ub     = b_neg ? (~b + 1'b1) : b;

   assign done = busy && (cnt == CW'(XLEN - 1));

   // One multiply step: conditional add into the high half, then shift right
   always_comb begin
      msum     = {1'b0, acc[2*XLEN-1:XLEN]} +
                 (acc[0] ? {1'b0, opnd} : '0);
      mul_next = {msum, acc[XLEN-1:1]};
   end

   // One restoring divide step on {remainder, quotient}
   always_comb begin
      dsub = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
      if (!dsub[XLEN])
         div_next = {dsub[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
         div_next = {acc[2*XLEN-2:0], 1'b0};
   end

   // Iteration state: load on start, step while busy
   always_ff @(posedge clk) begin
      if (!rst_n || kill) begin
         busy     <= 1'b0;
         cnt      <= '0;
         op_r     <= OP_ADD;
         is_div_r <= 1'b0;
         neg_lo   <= 1'b0;
         neg_hi   <= 1'b0;
         div0     <= 1'b0;
         a_keep   <= '0;
         opnd     <= '0;
         acc      <= '0;
      end else if (start) begin
         busy     <= 1'b1;
         cnt      <= '0;
         op_r     <= op;
         is_div_r <= is_div;
         neg_lo   <= a_neg ^ b_neg;
         neg_hi   <= is_div ? a_neg : (a_neg ^ b_neg);
         div0     <= is_div && (b == '0);
         a_keep   <= a;
         opnd     <= is_div ? ub : ua;
         acc      <= {{XLEN{1'b0}}, is_div ? ua : ub};
      end else if (busy) begin
         cnt <= cnt + CW'(1);
         acc <= is_div_r ? div_next : mul_next;
         if (done)
            busy <= 1'b0;
      end
   end

   // Sign fix-up and result select
   always_comb begin
      prod   = neg_lo ? (~acc + 1'b1) : acc;
      quo    = neg_lo ? (~acc[XLEN-1:0] + 1'b1)
                      : acc[XLEN-1:0];
      rem    = neg_hi ? (~acc[2*XLEN-1:XLEN] + 1'b1)
                      : acc[2*XLEN-1:XLEN];
      result = '0;
      case (op_r)
         OP_MUL:    result = prod[XLEN-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  result = prod[2*XLEN-1:XLEN];
         OP_DIV,
         OP_DIVU:   result = div0 ? '1 : quo;
         OP_REM,
         OP_REMU:   result = div0 ? a_keep : rem;
         default:   result = '0;
      endcase
   end

endmodule
`endif

// File: rtl/exec_stage_pipe.sv
// exec_stage_pipe: RV32I execute stage with valid/ready and EX/MEM register.
// EXEC_MULDIV_EN adds the iterative M-extension unit and its FSM.
module exec_stage_pipe
   import exec_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int SHAMT_W = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            ctl_alusrc,
   input  logic [1:0]      ctl_aluop,
   input  logic [2:0]      funct3,
   input  logic [6:0]      funct7,
   input  logic [4:0]      ctl_in,
   input  logic [4:0]      rd_in,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] alu_result,
   output logic [XLEN-1:0] pc_imm,
   output logic [XLEN-1:0] store_data,
   output logic            branch_taken,
   output logic [4:0]      ctl_out,
   output logic [4:0]      rd_out,
   output logic            illegal_op
);

   alu_op_e            op;
   logic               free;
   logic               accept;
   logic               is_md;
   logic               illegal;
   logic               cond;
   logic               taken;
   logic [XLEN-1:0]    op2;
   logic [XLEN-1:0]    alu_val;
   logic [XLEN-1:0]    pc_sum;
   logic [SHAMT_W-1:0] shamt;
   logic [4:0]         ctl_next;

   assign op      = alu_decode(ctl_aluop, funct3, funct7);
   assign illegal = (op == OP_ILL);
   assign op2     = (ctl_aluop == ALUOP_BR || !ctl_alusrc)
                    ? rs2_data : imm;
   assign shamt   = op2[SHAMT_W-1:0];
   assign pc_sum  = pc + (imm << 1);
   assign free    = !out_valid || out_ready;
   assign accept  = in_valid && in_ready;

`ifdef EXEC_MULDIV_EN
   state_e          state;
   logic            md_start;
   logic            md_busy;
   logic            md_done;
   logic [XLEN-1:0] md_result;
   logic [XLEN-1:0] md_pc_imm;
   logic [XLEN-1:0] md_store;
   logic [4:0]      md_ctl;
   logic [4:0]      md_rd;

   assign is_md    = op inside {OP_MUL, OP_MULH, OP_MULHSU,
                                OP_MULHU, OP_DIV, OP_DIVU,
                                OP_REM, OP_REMU};
   assign in_ready = free && !flush && (state == S_IDLE);
   assign md_start = accept && is_md;

   muldiv_iter #(
      .XLEN(XLEN)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .kill   (flush),
      .start  (md_start),
      .op     (op),
      .a      (rs1_data),
      .b      (rs2_data),
      .busy   (md_busy),
      .done   (md_done),
      .result (md_result)
   );

   // Mul/div sequencing: run the unit, then wait for a free slot
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: if (md_start) state <= S_BUSY;
            S_BUSY: if (md_done || !md_busy) state <= S_DONE;
            S_DONE: if (free) state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // Side-band fields of the mul/div instruction, held until write-back
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         md_pc_imm <= '0;
         md_store  <= '0;
         md_ctl    <= '0;
         md_rd     <= '0;
      end else if (md_start) begin
         md_pc_imm <= pc_sum;
         md_store  <= rs2_data;
         md_ctl    <= ctl_in;
         md_rd     <= rd_in;
      end
   end
`else
   assign is_md    = 1'b0;
   assign in_ready = free && !flush;
`endif

   // Integer ALU
   always_comb begin
      alu_val = '0;
      case (op)
         OP_ADD:  alu_val = rs1_data + op2;
         OP_SUB:  alu_val = rs1_data - op2;
         OP_AND:  alu_val = rs1_data & op2;
         OP_OR:   alu_val = rs1_data | op2;
         OP_XOR:  alu_val = rs1_data ^ op2;
         OP_SLL:  alu_val = rs1_data << shamt;
         OP_SRL:  alu_val = rs1_data >> shamt;
         OP_SRA:  alu_val = $unsigned($signed(rs1_data) >>> shamt);
         OP_SLT:  alu_val = {{(XLEN-1){1'b0}},
                             $signed(rs1_data) < $signed(op2)};
         OP_SLTU: alu_val = {{(XLEN-1){1'b0}}, rs1_data < op2};
         default: alu_val = '0;
      endcase
   end

   // Branch condition always compares the two register operands
   always_comb begin
      cond = 1'b0;
      case (funct3)
         F3_BEQ:  cond = (rs1_data == rs2_data);
         F3_BNE:  cond = (rs1_data != rs2_data);
         F3_BLT:  cond = ($signed(rs1_data) < $signed(rs2_data));
         F3_BGE:  cond = ($signed(rs1_data) >= $signed(rs2_data));
         F3_BLTU: cond = (rs1_data < rs2_data);
         F3_BGEU: cond = (rs1_data >= rs2_data);
         default: cond = 1'b0;
      endcase
   end

   // Illegal instructions flow through but must not write a register
   always_comb begin
      taken    = cond && ctl_in[CTL_BRANCH] &&
                 (ctl_aluop == ALUOP_BR) && !illegal;
      ctl_next = ctl_in;
      if (illegal)
         ctl_next[CTL_REGWRITE] = 1'b0;
   end

   // EX/MEM output slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         alu_result   <= '0;
         pc_imm       <= '0;
         store_data   <= '0;
         branch_taken <= 1'b0;
         ctl_out      <= '0;
         rd_out       <= '0;
         illegal_op   <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept && !is_md) begin
         out_valid    <= 1'b1;
         alu_result   <= alu_val;
         pc_imm       <= pc_sum;
         store_data   <= rs2_data;
         branch_taken <= taken;
         ctl_out      <= ctl_next;
         rd_out       <= rd_in;
         illegal_op   <= illegal;
      end
`ifdef EXEC_MULDIV_EN
      else if (state == S_DONE && free) begin
         out_valid    <= 1'b1;
         alu_result   <= md_result;
         pc_imm       <= md_pc_imm;
         store_data   <= md_store;
         branch_taken <= 1'b0;
         ctl_out      <= md_ctl;
         rd_out       <= md_rd;
         illegal_op   <= 1'b0;
      end
`endif
      else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/exec_stage_pipe.md
Name: exec_stage_pipe

Overview:
- Parametrised successor to the single-cycle execute stage; sits between the decode/register-read and memory pipeline registers.
- Full RV32I integer ALU, funct3-correct branch resolution and a valid/ready handshake on both sides, so the stage can stall.
- Optional iterative multiply/divide unit (RV M extension) that occupies the stage for multiple cycles.
- Output register doubles as the EX/MEM pipeline register.

Parameters:
- XLEN, 32, datapath width; power of two, at least 8.
- SHAMT_W, $clog2(XLEN), shift-amount width taken from the low bits of operand 2.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  synchronous reset, active-low: sampled on the rising edge of clk, asserted when 0.
- flush  in  1  kill the in-flight instruction and the output slot.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle (combinational).
- ctl_alusrc  in  1  1 selects imm as operand 2.
- ctl_aluop  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- funct3  in  3  instruction funct3.
- funct7  in  7  instruction funct7.
- ctl_in  in  5  {memtoreg, regwrite, memread, memwrite, branch}; passed through.
- rd_in  in  5  destination register; passed through.
- rs1_data, rs2_data, imm, pc  in  XLEN each  operands.
- out_valid  out  1  output slot holds a result.
- out_ready  in  1  downstream consumes the slot.
- alu_result  out  XLEN  ALU or mul/div result.
- pc_imm  out  XLEN  pc + (imm << 1).
- store_data  out  XLEN  rs2_data, never the immediate.
- branch_taken  out  1  branch condition true AND ctl_in.branch.
- ctl_out  out  5  registered ctl_in.
- rd_out  out  5  registered rd_in.
- illegal_op  out  1  decode matched no supported operation.

Behaviour:
- Reset: all outputs 0; FSM returns to IDLE; an in-flight mul/div is abandoned. in_ready=1 in the first cycle after reset.
- Accept and output-slot rules:
  - Slot is free when !out_valid || out_ready.
  - in_ready = free && state==IDLE && !flush.
  - Accept = in_valid && in_ready.
- Single-cycle op: result is registered on the accept edge; out_valid=1 on the next cycle (latency 1).
- Hold: the output slot holds all its fields stable while out_valid && !out_ready.
- ALU operations, selected by aluop/funct3/funct7:
  - add, sub, and, or, xor, sll, srl, sra, slt, sltu.
  - I-type (aluop 11) ignores funct7, except bit 5 for srai.
  - aluop 00 always adds.
- Shifts use operand2[SHAMT_W-1:0] only. Results wrap modulo 2^XLEN.
- Branches (aluop 01):
  - beq/bne, blt/bge (signed), bltu/bgeu (unsigned).
  - Compare rs1_data against rs2_data, regardless of ctl_alusrc.
  - alu_result = rs1 - rs2.
  - funct3 010/011 is illegal.
- Illegal encoding: illegal_op=1, alu_result=0, branch_taken=0, regwrite forced to 0 in ctl_out. The instruction still flows through.
- FSM states IDLE, BUSY, DONE; used only for mul/div.
  - IDLE -> BUSY on accept of a mul/div.
  - BUSY runs XLEN iterations with a counter.
  - BUSY -> DONE when the counter reaches XLEN-1.
  - DONE -> IDLE on the edge where the result is written into the free slot; DONE waits while the slot is not free.
- Mul/div latency: accept to out_valid = XLEN+1 cycles, or more if the slot is not free.
- Divide by zero: quotient = all ones; remainder = dividend.
- Signed overflow (min / -1): quotient = min; remainder = 0.
- flush: out_valid<=0 and FSM<=IDLE on the same edge; any accept is suppressed. flush and rst_n together behave as reset.
- out_ready while !out_valid: no effect.

Optional Feature:
- Macro: EXEC_MULDIV_EN.
- Defined:
  - aluop 10 with funct7 = 0000001 decodes mul, mulh, mulhsu, mulhu, div, divu, rem, remu.
  - These run on the iterative unit described above.
- Undefined:
  - The FSM and iterative unit are absent; the stage is strictly latency 1.
  - Those encodings set illegal_op=1.

Decomposition:
- Package exec_pkg:
  - ALU op enum: ADD, SUB, AND, OR, XOR, SLL, SRL, SRA, SLT, SLTU, MUL*, DIV*, REM*.
  - aluop encodings.
  - Branch funct3 constants.
  - FSM state enum.
  - ctl bundle bit positions.
- Sub-module muldiv_iter (guarded by EXEC_MULDIV_EN):
  - Shift-add multiplier and restoring divider.
  - start/busy/done handshake with the stage FSM.

Test Plan:
- add, ctl_alusrc=0, rs1=5, rs2=-7, out_ready=1 -> next cycle alu_result=0xFFFFFFFE, out_valid=1, store_data=-7.
- sra rs1=0x80000000, rs2=0x24 (shamt 4) -> 0xF8000000; srl of the same operands -> 0x08000000.
- bltu rs1=1, rs2=0xFFFFFFFF, ctl branch=1 -> branch_taken=1; blt with the same operands -> 0. pc=0x100, imm=8 -> pc_imm=0x110.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, outputs stable; out_ready=1 -> next instruction accepted on that edge.
- With EXEC_MULDIV_EN:
  - div 0x80000000 / 0xFFFFFFFF -> 0x80000000, out_valid at accept+33.
  - divu 7/0 -> 0xFFFFFFFF.
  - flush during BUSY -> out_valid stays 0, in_ready=1 next cycle.
- rst_n=0 mid-mul/div for one edge -> all outputs 0; funct3=010 with aluop 01 -> illegal_op=1, ctl_out regwrite=0.
